// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave memory controller.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

    // General call (0x00) and the 10-bit prefix 11110xx never match.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] slave_addr);
        return (addr_byte[7:1] == slave_addr) &&
               (addr_byte[7:1] != 7'h00) &&
               (addr_byte[7:3] != 5'b11110);
    endfunction

endpackage

// File: rtl/i2c_slave_mem_ctrl_if.sv
// Pad-side I2C lines plus the single-cycle memory bus of the I2C slave.
interface i2c_slave_mem_ctrl_if;

    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       mem_ce;
    logic       mem_wren;
    logic       mem_rden;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, mem_rdata,
        output sda_oe, mem_ce, mem_wren, mem_rden, mem_addr, mem_wdata, busy
    );

    modport master (
        output scl_i, sda_i, mem_rdata,
        input  sda_oe, mem_ce, mem_wren, mem_rden, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and produces registered SCL edge and START/STOP events.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [STAGES-1:0] scl_sync;
    logic [STAGES-1:0] sda_sync;
    logic              scl_d;
    logic              sda_d;
    logic              scl_s;
    logic              sda_s;

    assign scl_s = scl_sync[STAGES-1];
    assign sda_s = sda_sync[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: synchronizer flops reset to the idle-high bus level so that
            // leaving reset can never fabricate a START or STOP event.
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            sda      <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            sda      <= sda_s;
            scl_rise <= scl_s & ~scl_d;
            scl_fall <= ~scl_s & scl_d;
            start    <= scl_s & scl_d & sda_d & ~sda_s;
            stop     <= scl_s & scl_d & ~sda_d & sda_s;
        end
    end

endmodule

// File: rtl/i2c_slave_mem_ctrl.sv
// I2C slave protocol engine: turns bus transactions into single-cycle memory
// accesses through an auto-incrementing 8-bit byte pointer.
module i2c_slave_mem_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_slave_mem_ctrl_if.slave  bus
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    state_e     state;
    logic [3:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] ptr;
    logic       rw;
    logic       ack_on;   // ACK states: ACK driven; RD_ACK: master acked
    logic       rd_pend;
    logic [7:0] rx_byte;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (bus.scl_i),
        .sda_i    (bus.sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign rx_byte = {rx_shift[6:0], sda};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            ptr           <= '0;
            rw            <= 1'b0;
            ack_on        <= 1'b0;
            rd_pend       <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.mem_ce    <= 1'b0;
            bus.mem_wren  <= 1'b0;
            bus.mem_rden  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking, so every test below sees
            // the pre-edge value (e.g. mem_addr <= ptr uses ptr before ptr++).
            bus.mem_ce   <= 1'b0;
            bus.mem_wren <= 1'b0;
            bus.mem_rden <= 1'b0;
            rd_pend      <= bus.mem_rden;
            if (rd_pend)
                tx_shift <= bus.mem_rdata;

            if (start) begin
                state      <= ST_ADDR;
                bit_cnt    <= '0;
                ack_on     <= 1'b0;
                bus.sda_oe <= 1'b0;
            end else if (stop) begin
                state      <= ST_IDLE;
                ack_on     <= 1'b0;
                bus.sda_oe <= 1'b0;
                bus.busy   <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        rx_shift <= rx_byte;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            ack_on  <= 1'b0;
                            if (state == ST_ADDR) begin
                                if (addr_match(rx_byte, SLAVE_ADDR)) begin
                                    state    <= ST_ADDR_ACK;
                                    bus.busy <= 1'b1;
                                    rw       <= rx_byte[0];
                                    if (rx_byte[0] == RW_READ) begin
                                        bus.mem_ce   <= 1'b1;
                                        bus.mem_rden <= 1'b1;
                                        bus.mem_addr <= ptr;
                                    end
                                end else begin
                                    state    <= ST_IGNORE;
                                    bus.busy <= 1'b0;
                                end
                            end else if (state == ST_PTR) begin
                                ptr   <= rx_byte;
                                state <= ST_PTR_ACK;
                            end else begin
                                bus.mem_ce    <= 1'b1;
                                bus.mem_wren  <= 1'b1;
                                bus.mem_addr  <= ptr;
                                bus.mem_wdata <= rx_byte;
                                ptr           <= ptr + 8'd1;
                                state         <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA: bit_cnt <= bit_cnt + 4'd1;
                    ST_RD_ACK: begin
                        ptr <= ptr + 8'd1;
                        if (sda == NACK) begin
                            state <= ST_IGNORE;
                        end else begin
                            ack_on       <= 1'b1;
                            bus.mem_ce   <= 1'b1;
                            bus.mem_rden <= 1'b1;
                            bus.mem_addr <= ptr + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (!ack_on) begin
                            bus.sda_oe <= ~ACK;
                            ack_on     <= 1'b1;
                        end else begin
                            ack_on  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == ST_ADDR_ACK && rw == RW_READ) begin
                                state      <= ST_RDATA;
                                bus.sda_oe <= ~tx_shift[7];
                                tx_shift   <= tx_shift << 1;
                            end else begin
                                bus.sda_oe <= 1'b0;
                                state      <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (bit_cnt == 4'd8) begin
                            bus.sda_oe <= 1'b0;
                            ack_on     <= 1'b0;
                            state      <= ST_RD_ACK;
                        end else begin
                            bus.sda_oe <= ~tx_shift[7];
                            tx_shift   <= tx_shift << 1;
                        end
                    end
                    ST_RD_ACK: begin
                        if (ack_on) begin
                            ack_on     <= 1'b0;
                            bit_cnt    <= '0;
                            state      <= ST_RDATA;
                            bus.sda_oe <= ~tx_shift[7];
                            tx_shift   <= tx_shift << 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem_ctrl.sv
// Randomized bench: an I2C master model drives the slave, a memory model sits
// on the memory bus, and a scoreboard checks every memory access.
module tb_i2c_slave_mem_ctrl;
    import i2c_pkg::*;

    localparam logic [6:0] SLAVE = 7'h50;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    acc_t       exp_q[$];
    logic [7:0] wq[$];
    logic [7:0] bus_mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] mptr;

    always #5 clk = ~clk;

    i2c_slave_mem_ctrl_if bus();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    i2c_slave_mem_ctrl #(.SLAVE_ADDR(SLAVE), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory on the slave's bus; read data appears the clock after rden.
    always @(posedge clk) begin
        if (bus.mem_ce && bus.mem_wren) bus_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_ce && bus.mem_rden) bus.mem_rdata <= bus_mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic acc_t mk(input logic wr, input logic [7:0] a, input logic [7:0] d);
        acc_t e;
        e.wr = wr; e.addr = a; e.data = d;
        return e;
    endfunction

    // Scoreboard monitor: every strobe must match the next expected access.
    always @(negedge clk) begin
        if (!reset && (bus.mem_ce || bus.mem_wren || bus.mem_rden)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_access: wren=%0b rden=%0b addr=%0h, none expected",
                         bus.mem_wren, bus.mem_rden, bus.mem_addr);
            end else begin
                acc_t e;
                e = exp_q.pop_front();
                check("acc_ce", bus.mem_ce, 1'b1);
                check("acc_kind", {bus.mem_wren, bus.mem_rden}, {e.wr, ~e.wr});
                check("acc_addr", bus.mem_addr, e.addr);
                if (e.wr) check("acc_wdata", bus.mem_wdata, e.data);
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- I2C master bit level ----------------
    task automatic send_bit(input logic b, output logic sampled);
        m_sda = b;
        #60 m_scl = 1'b1;
        #50 sampled = bus.sda_i;
        #50 m_scl = 1'b0;
        #60;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(master_ack, s);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        #60 m_scl = 1'b1;
        #60 m_sda = 1'b0;
        #60 m_scl = 1'b0;
        #60;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        #60 m_scl = 1'b1;
        #60 m_sda = 1'b1;
        #200;
    endtask

    // ---------------- transaction level with reference model ----------------
    task automatic set_ptr(input logic [7:0] p);
        logic a;
        i2c_start();
        send_byte({SLAVE, 1'b0}, a);
        check("addr_w_ack", a, ACK);
        check("busy_after_match", bus.busy, 1'b1);
        send_byte(p, a);
        check("ptr_ack", a, ACK);
        mptr = p;
    endtask

    task automatic do_write(input logic [7:0] p);
        logic a;
        set_ptr(p);
        foreach (wq[i]) begin
            exp_q.push_back(mk(1'b1, mptr, wq[i]));
            ref_mem[mptr] = wq[i];
            mptr = mptr + 8'd1;
            send_byte(wq[i], a);
            check("wdata_ack", a, ACK);
        end
        i2c_stop();
        check("busy_after_stop", bus.busy, 1'b0);
        check("sda_rel_after_stop", bus.sda_oe, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] p, input int n);
        logic       a;
        logic [7:0] d;
        logic [7:0] expd;
        set_ptr(p);
        i2c_start();
        exp_q.push_back(mk(1'b0, mptr, 8'h00));
        send_byte({SLAVE, RW_READ}, a);
        check("addr_r_ack", a, ACK);
        for (int k = 0; k < n; k++) begin
            a = (k == n - 1) ? NACK : ACK;
            expd = ref_mem[mptr];
            mptr = mptr + 8'd1;
            if (a == ACK) exp_q.push_back(mk(1'b0, mptr, 8'h00));
            recv_byte(a, d);
            check("rdata", d, expd);
        end
        i2c_stop();
        check("busy_after_rd_stop", bus.busy, 1'b0);
    endtask

    task automatic do_mismatch(input logic [7:0] addr_byte);
        logic a;
        i2c_start();
        send_byte(addr_byte, a);
        check("mismatch_nack", a, NACK);
        check("mismatch_busy", bus.busy, 1'b0);
        check("mismatch_sda_oe", bus.sda_oe, 1'b0);
        send_byte(8'h55, a);
        check("ignored_byte_nack", a, NACK);
        check("ignored_busy", bus.busy, 1'b0);
        i2c_stop();
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] rp;
        int         op;
        int         len;
        logic [6:0] bad;

        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        bus.mem_rdata = 8'h00;
        mptr = 8'h00;

        repeat (5) @(posedge clk);
        #1 check("reset_outputs",
                 {bus.sda_oe, bus.mem_ce, bus.mem_wren, bus.mem_rden, bus.busy,
                  bus.mem_addr, bus.mem_wdata}, 21'd0);
        @(negedge clk) reset = 1'b0;
        #200;

        // Directed write then read-back with repeated START.
        wq = {};
        wq.push_back(8'hA5);
        wq.push_back(8'h3C);
        do_write(8'h10);
        check("ptr_after_write", dut.ptr, 8'h12);
        do_read(8'h10, 2);

        do_mismatch(8'hA2);

        // Pointer wrap.
        wq = {};
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        do_write(8'hFF);
        check("wrap_mem_ff", bus_mem[8'hFF], 8'h11);
        check("wrap_mem_00", bus_mem[8'h00], 8'h22);
        do_read(8'hFF, 2);

        // STOP three bits into a data byte: no write may happen.
        set_ptr(8'h40);
        send_bit(1'b1, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        i2c_stop();
        check("partial_sda_oe", bus.sda_oe, 1'b0);
        check("partial_busy", bus.busy, 1'b0);

        // Reset while the slave drives a 0 data bit.
        wq = {};
        wq.push_back(8'h00);
        wq.push_back(8'h7F);
        do_write(8'h20);
        set_ptr(8'h20);
        i2c_start();
        exp_q.push_back(mk(1'b0, mptr, 8'h00));
        send_byte({SLAVE, RW_READ}, a);
        check("rst_addr_ack", a, ACK);
        check("rst_sda_driven", bus.sda_oe, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 check("midreset_outputs",
                 {bus.sda_oe, bus.mem_ce, bus.mem_wren, bus.mem_rden, bus.busy,
                  bus.mem_addr, bus.mem_wdata}, 21'd0);
        @(negedge clk) reset = 1'b0;
        m_sda = 1'b1;
        #60 m_scl = 1'b1;
        #200;
        do_read(8'h20, 2);

        // Randomized traffic.
        for (int t = 0; t < 12; t++) begin
            op  = $urandom_range(0, 2);
            len = $urandom_range(1, 4);
            rp  = 8'($urandom);
            if (op == 0) begin
                wq = {};
                for (int k = 0; k < len; k++) wq.push_back(8'($urandom));
                do_write(rp);
            end else if (op == 1) begin
                do_read(rp, len);
            end else begin
                bad = 7'($urandom_range(0, 127));
                if (bad == SLAVE) bad = 7'h00;
                do_mismatch({bad, 1'($urandom)});
            end
        end

        #500;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
